// File: rtl/fb_slice_writer_if.sv
// fb_slice_writer_if: pixel input, framebuffer write and slice handshake bundle.
// dropped_frames exists only with FB_SLICE_WRITER_DROP_CNT_EN.
interface fb_slice_writer_if #(
   parameter int PIX_W  = 24,
   parameter int ADDR_W = 11
);
   logic [PIX_W-1:0]  pixel_data;
   logic              pixel_valid;
   logic [2:0]        pixel_col;
   logic [3:0]        pixel_line;
   logic [2:0]        block_col;
   logic [1:0]        block_line;
   logic              fb_wr_en;
   logic [ADDR_W:0]   fb_wr_addr;
   logic [PIX_W-1:0]  fb_wr_data;
   logic              rd_bank;
   logic              frame_valid;
   logic              frame_ack;
   logic              desync;
`ifdef FB_SLICE_WRITER_DROP_CNT_EN
   logic [15:0]       dropped_frames;
`endif

   modport slave (
      input  pixel_data, pixel_valid, pixel_col, pixel_line, block_col, block_line, frame_ack,
`ifdef FB_SLICE_WRITER_DROP_CNT_EN
      output dropped_frames,
`endif
      output fb_wr_en, fb_wr_addr, fb_wr_data, rd_bank, frame_valid, desync
   );

   modport master (
      output pixel_data, pixel_valid, pixel_col, pixel_line, block_col, block_line, frame_ack,
`ifdef FB_SLICE_WRITER_DROP_CNT_EN
      input  dropped_frames,
`endif
      input  fb_wr_en, fb_wr_addr, fb_wr_data, rd_bank, frame_valid, desync
   );
endinterface

// File: rtl/fb_slice_writer.sv
// fb_slice_writer: linearises µblock pixel coordinates into a double-buffered slice RAM.
// Optional saturating drop counter enabled by FB_SLICE_WRITER_DROP_CNT_EN.
module fb_slice_writer #(
   parameter int N_BLOCK_COLS  = 5,
   parameter int N_BLOCK_LINES = 3,
   parameter int PIX_W         = 24,
   parameter int ADDR_W        = 11
) (
   input logic              clk,
   input logic              rst,
   fb_slice_writer_if.slave bus
);
   typedef enum logic [1:0] {SYNC, FILL, HOLD} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BLOCK_COLS * N_BLOCK_LINES * 128 - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr, exp_q, exp_d;
   logic              bank_q, bank_d, fv_q, fv_d, wen_q, wen_d, desync_q, desync_d, swap;
   logic [ADDR_W:0]   waddr_q, waddr_d;
   logic [PIX_W-1:0]  wdata_q, wdata_d;

   assign addr = ADDR_W'((32'(bus.block_line) * N_BLOCK_COLS + 32'(bus.block_col)) * 128
                         + 32'(bus.pixel_line) * 8 + 32'(bus.pixel_col));

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      wen_d    = 1'b0;
      desync_d = 1'b0;
      swap     = 1'b0;
      case (state_q)
         SYNC: if (bus.pixel_valid && addr == '0) begin
            wen_d   = 1'b1;
            exp_d   = ADDR_W'(1);
            state_d = FILL;
         end
         FILL: if (bus.pixel_valid) begin
            if (addr == exp_q) begin
               wen_d = 1'b1;
               exp_d = exp_q + 1'b1;
               // LAST still lands in the old bank; the swap only affects later pixels
               if (addr == LAST) begin
                  if (!fv_q || bus.frame_ack) begin
                     swap  = 1'b1;
                     exp_d = '0;
                  end else state_d = HOLD;
               end
            end else begin
               desync_d = 1'b1;
               if (addr == '0) begin
                  wen_d = 1'b1;
                  exp_d = ADDR_W'(1);
               end else state_d = SYNC;
            end
         end
         HOLD: if (bus.frame_ack) begin
            swap    = 1'b1;
            state_d = SYNC;
         end
         default: state_d = SYNC;
      endcase
      bank_d  = bank_q ^ swap;
      fv_d    = swap ? 1'b1 : (bus.frame_ack ? 1'b0 : fv_q);
      waddr_d = wen_d ? {bank_q, addr} : waddr_q;
      wdata_d = wen_d ? bus.pixel_data : wdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= SYNC;
         exp_q    <= '0;
         bank_q   <= 1'b0;
         fv_q     <= 1'b0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         desync_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         bank_q   <= bank_d;
         fv_q     <= fv_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         desync_q <= desync_d;
      end
   end

   assign bus.fb_wr_en    = wen_q;
   assign bus.fb_wr_addr  = waddr_q;
   assign bus.fb_wr_data  = wdata_q;
   assign bus.rd_bank     = ~bank_q;
   assign bus.frame_valid = fv_q;
   assign bus.desync      = desync_q;

`ifdef FB_SLICE_WRITER_DROP_CNT_EN
   logic [15:0] drop_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop_q <= '0;
      else if (state_q == FILL && state_d == HOLD && ~&drop_q) drop_q <= drop_q + 1'b1;
   end
   assign bus.dropped_frames = drop_q;
`endif
endmodule

// File: tb/tb_fb_slice_writer.sv
// tb_fb_slice_writer: directed stimulus with a write scoreboard for fb_slice_writer.
module tb_fb_slice_writer;
   localparam int PIX_W  = 24;
   localparam int ADDR_W = 11;
   localparam int LAST   = 1919;

   typedef struct {
      logic [ADDR_W:0]  addr;
      logic [PIX_W-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0, fails = 0, desync_cnt = 0, tag = 0;
   logic wb = 1'b0;
   wr_t  sb[$];

   fb_slice_writer_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

   fb_slice_writer #(.N_BLOCK_COLS(5), .N_BLOCK_LINES(3), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (bus.desync) desync_cnt++;
      if (bus.fb_wr_en) begin
         tests++;
         assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.fb_wr_addr, bus.fb_wr_data);
         end
         if (sb.size() > 0) begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", 32'(bus.fb_wr_addr), 32'(e.addr));
            chk("wr_data", 32'(bus.fb_wr_data), 32'(e.data));
         end
      end
   end

   task automatic pix(input int a, input bit wr, input bit ack = 1'b0);
      int blk;
      wr_t e;
      @(negedge clk);
      blk = a / 128;
      bus.pixel_valid = 1'b1;
      bus.frame_ack   = ack;
      bus.pixel_data  = PIX_W'(a + tag * 4096);
      bus.block_line  = 2'(blk / 5);
      bus.block_col   = 3'(blk % 5);
      bus.pixel_line  = 4'((a % 128) / 8);
      bus.pixel_col   = 3'(a % 8);
      if (wr) begin
         e.addr = {wb, ADDR_W'(a)};
         e.data = PIX_W'(a + tag * 4096);
         sb.push_back(e);
      end
   endtask

   task automatic idle(input bit ack = 1'b0);
      @(negedge clk);
      bus.pixel_valid = 1'b0;
      bus.frame_ack   = ack;
   endtask

   task automatic chk_reset_vals();
      chk("rst_wr_en", 32'(bus.fb_wr_en), 0);
      chk("rst_wr_addr", 32'(bus.fb_wr_addr), 0);
      chk("rst_wr_data", 32'(bus.fb_wr_data), 0);
      chk("rst_rd_bank", 32'(bus.rd_bank), 1);
      chk("rst_frame_valid", 32'(bus.frame_valid), 0);
      chk("rst_desync", 32'(bus.desync), 0);
`ifdef FB_SLICE_WRITER_DROP_CNT_EN
      chk("rst_dropped", 32'(bus.dropped_frames), 0);
`endif
   endtask

   initial begin
      int d0;
      bus.pixel_valid = 1'b0; bus.frame_ack = 1'b0; bus.pixel_data = '0;
      bus.pixel_col = '0; bus.pixel_line = '0; bus.block_col = '0; bus.block_line = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      // slice 1 into bank 0
      for (int a = 0; a <= LAST; a++) pix(a, 1'b1);
      idle();
      chk("s1_rd_bank", 32'(bus.rd_bank), 0);
      chk("s1_frame_valid", 32'(bus.frame_valid), 1);
      // slice 2 into bank 1, unacknowledged, so it parks in HOLD
      tag = 1; wb = 1'b1;
      for (int a = 0; a <= LAST; a++) pix(a, 1'b1);
      idle();
      chk("s2_rd_bank", 32'(bus.rd_bank), 0);
      chk("s2_frame_valid", 32'(bus.frame_valid), 1);
`ifdef FB_SLICE_WRITER_DROP_CNT_EN
      chk("s2_dropped", 32'(bus.dropped_frames), 1);
`endif
      tag = 2;
      for (int a = 0; a <= 50; a++) pix(a, 1'b0);
      idle(1'b1);
      idle();
      chk("hold_ack_rd_bank", 32'(bus.rd_bank), 1);
      chk("hold_ack_frame_valid", 32'(bus.frame_valid), 1);
      // SYNC after HOLD: ignore until addr 0, then fill bank 0
      wb = 1'b0; tag = 3;
      pix(5, 1'b0);
      for (int a = 0; a < 100; a++) pix(a, 1'b1);
      d0 = desync_cnt;
      pix(105, 1'b0);
      idle();
      idle();
      chk("desync_once", 32'(desync_cnt), 32'(d0 + 1));
      pix(37, 1'b0);
      pix(0, 1'b1);
      pix(1, 1'b1);
      pix(0, 1'b1);
      idle();
      idle();
      chk("desync_fill_zero", 32'(desync_cnt), 32'(d0 + 2));
      // LAST with simultaneous ack while frame_valid is set
      for (int a = 1; a < LAST; a++) pix(a, 1'b1);
      pix(LAST, 1'b1, 1'b1);
      idle();
      chk("ack_last_rd_bank", 32'(bus.rd_bank), 0);
      chk("ack_last_frame_valid", 32'(bus.frame_valid), 1);
`ifdef FB_SLICE_WRITER_DROP_CNT_EN
      chk("ack_last_dropped", 32'(bus.dropped_frames), 1);
`endif
      idle(1'b1);
      idle();
      chk("ack_clear_frame_valid", 32'(bus.frame_valid), 0);
      chk("ack_clear_rd_bank", 32'(bus.rd_bank), 0);
      idle(1'b1);
      idle();
      chk("ack_ignored_frame_valid", 32'(bus.frame_valid), 0);
      // reset, then a stream entering mid-slice
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      wb = 1'b0; tag = 4;
      d0 = desync_cnt;
      for (int a = 37; a <= 60; a++) pix(a, 1'b0);
      idle();
      chk("sync_no_desync", 32'(desync_cnt), 32'(d0));
      // reset asserted while pixel 800 is presented
      for (int a = 0; a < 800; a++) pix(a, 1'b1);
      pix(800, 1'b0);
      chk("pre_rst_wr_en", 32'(bus.fb_wr_en), 1);
      #1 rst = 1'b1;
      #1 chk_reset_vals();
      idle();
      rst = 1'b0;
      tag = 5;
      for (int a = 0; a <= LAST; a++) pix(a, 1'b1);
      idle();
      chk("post_rst_rd_bank", 32'(bus.rd_bank), 0);
      chk("post_rst_frame_valid", 32'(bus.frame_valid), 1);
      repeat (3) idle();
      chk("scoreboard_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
